// File: rtl/fenwick_mmio_if.sv
// Register-bus bundle between a SoC bus master and the Fenwick engine.
// The level interrupt travels with the bus so the peripheral exposes one port group.
interface fenwick_mmio_if #(
  parameter int DATA_W = 32
);
  logic              bus_sel;
  logic              bus_wen;
  logic [2:0]        bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;
  logic              irq;

  modport master (
    output bus_sel, bus_wen, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready, irq
  );

  modport slave (
    input  bus_sel, bus_wen, bus_addr, bus_wdata,
    output bus_rdata, bus_ready, irq
  );
endinterface

// File: rtl/fenwick_mmio_engine.sv
// Memory-mapped Fenwick tree engine: one tree node per clock, commands issued over a
// register bus, start/busy/done handshake with a level interrupt.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start or clear
// CLR     | zero node i (tree and array), i = 0..DEPTH
// LOAD    | validate command, compute delta / seed accumulators
// WALK_UP | ft[i] += delta, i += lowbit(i) until i > DEPTH
// WALK_HI | s1 += ft[i], i -= lowbit(i) until i == 0 (prefix up to qr)
// WALK_LO | s0 += ft[i] down from ql, then RESULT = s1 - s0
// FIN     | one cycle with done freshly set; accepts a new command
module fenwick_mmio_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 100
) (
  input logic            clk,
  input logic            rst_n,
  fenwick_mmio_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH + 1) + 1;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);
  localparam logic [IDX_W-1:0]  DEPTH_I = IDX_W'(DEPTH);
  localparam logic [AW-1:0]     DEPTH_A = AW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_WALK_UP, S_WALK_HI, S_WALK_LO, S_FIN
  } state_t;

  typedef enum logic [1:0] {OP_APPEND = 2'b00, OP_QUERY = 2'b01, OP_SET = 2'b10, OP_ADD = 2'b11} op_t;

  logic [DATA_W-1:0] ft  [0:DEPTH];
  logic [DATA_W-1:0] arr [0:DEPTH];

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [AW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] arg0_q, arg0_d, arg1_q, arg1_d, result_q, result_d;
  logic [DATA_W-1:0] delta_q, delta_d, s1_q, s1_d, s0_q, s0_d;
  logic              done_q, done_d, err_q, err_d, ovr_q, ovr_d, irqen_q, irqen_d;
  logic              ready_q, ready_d, irq_q, irq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ft_we, arr_we;
  logic [AW-1:0]     ft_wa, arr_wa, arr_ra;
  logic [DATA_W-1:0] ft_wd, arr_wd, ft_rd, arr_rd;
  logic [IDX_W-1:0]  lowbit, i_up, i_dn;
  logic              busy, full, wr, rd, start_req, clr_req;

  always_ff @(posedge clk) begin
    if (ft_we)  ft[ft_wa]   <= ft_wd;
    if (arr_we) arr[arr_wa] <= arr_wd;
  end

  always_comb begin
    state_d  = state_q;   op_d    = op_q;     i_d      = i_q;      count_d = count_q;
    arg0_d   = arg0_q;    arg1_d  = arg1_q;   result_d = result_q; delta_d = delta_q;
    s1_d     = s1_q;      s0_d    = s0_q;     done_d   = done_q;   err_d   = err_q;
    ovr_d    = ovr_q;     irqen_d = irqen_q;
    ft_we    = 1'b0;      ft_wa   = i_q[AW-1:0];  ft_wd  = '0;
    arr_we   = 1'b0;      arr_wa  = '0;           arr_wd = '0;

    busy   = (state_q != S_IDLE) && (state_q != S_FIN);
    full   = (count_q == DEPTH_A);
    lowbit = i_q & (~i_q + IDX_W'(1));
    i_up   = i_q + lowbit;
    i_dn   = i_q - lowbit;
    ft_rd  = (i_q <= DEPTH_I) ? ft[i_q[AW-1:0]] : '0;
    arr_ra = arg0_q[AW-1:0];
    arr_rd = (arr_ra <= DEPTH_A) ? arr[arr_ra] : '0;

    wr        = bus.bus_sel & bus.bus_wen;
    rd        = bus.bus_sel & ~bus.bus_wen;
    start_req = wr && (bus.bus_addr == 3'd0) && bus.bus_wdata[4];
    clr_req   = wr && (bus.bus_addr == 3'd0) && bus.bus_wdata[5];
    ready_d   = bus.bus_sel;
    rdata_d   = '0;

    if (rd) begin
      case (bus.bus_addr)
        3'd1:    rdata_d = {{(DATA_W-5){1'b0}}, ovr_q, full, err_q, done_q, busy};
        3'd2:    rdata_d = arg0_q;
        3'd3:    rdata_d = arg1_q;
        3'd4:    rdata_d = result_q;
        3'd5:    rdata_d = DATA_W'(count_q);
        3'd6:    rdata_d = {{(DATA_W-1){1'b0}}, irqen_q};
        default: rdata_d = '0;
      endcase
    end

    // W1C is applied first so any hardware set below in the same cycle wins.
    if (wr) begin
      case (bus.bus_addr)
        3'd1: begin
          if (bus.bus_wdata[1]) done_d = 1'b0;
          if (bus.bus_wdata[2]) err_d  = 1'b0;
          if (bus.bus_wdata[4]) ovr_d  = 1'b0;
        end
        3'd2:    if (!busy) arg0_d = bus.bus_wdata;
        3'd3:    if (!busy) arg1_d = bus.bus_wdata;
        3'd6:    irqen_d = bus.bus_wdata[0];
        default: ;
      endcase
    end
    if (busy && (start_req || clr_req)) ovr_d = 1'b1;

    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (clr_req) begin
          state_d = S_CLR;
          i_d     = '0;
          done_d  = 1'b0;
        end else if (start_req) begin
          state_d = S_LOAD;
          op_d    = op_t'(bus.bus_wdata[1:0]);
          done_d  = 1'b0;
        end
      end
      S_CLR: begin
        ft_we  = 1'b1;
        arr_we = 1'b1;
        arr_wa = i_q[AW-1:0];
        if (i_q == DEPTH_I) begin
          count_d = '0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          i_d = i_q + IDX_W'(1);
        end
      end
      S_LOAD: begin
        if (op_q == OP_QUERY) begin
          if (arg1_q >= DEPTH_D || arg0_q > arg1_q) begin
            err_d = 1'b1; done_d = 1'b1; state_d = S_FIN;
          end else begin
            s1_d = '0; s0_d = '0;
            i_d  = IDX_W'(arg1_q[AW-1:0]) + IDX_W'(1);
            state_d = S_WALK_HI;
          end
        end else if (op_q == OP_APPEND) begin
          if (full) begin
            err_d = 1'b1; done_d = 1'b1; state_d = S_FIN;
          end else begin
            arr_we  = 1'b1;
            arr_wa  = count_q;
            arr_wd  = arg1_q;
            delta_d = arg1_q;
            i_d     = IDX_W'(count_q) + IDX_W'(1);
            state_d = S_WALK_UP;
          end
        end else begin
          if (arg0_q >= DEPTH_D) begin
            err_d = 1'b1; done_d = 1'b1; state_d = S_FIN;
          end else begin
            arr_we  = 1'b1;
            arr_wa  = arr_ra;
            arr_wd  = (op_q == OP_SET) ? arg1_q : arr_rd + arg1_q;
            delta_d = (op_q == OP_SET) ? arg1_q - arr_rd : arg1_q;
            i_d     = IDX_W'(arr_ra) + IDX_W'(1);
            state_d = S_WALK_UP;
          end
        end
      end
      S_WALK_UP: begin
        ft_we = 1'b1;
        ft_wd = ft_rd + delta_q;
        if (i_up > DEPTH_I) begin
          if (op_q == OP_APPEND) count_d = count_q + AW'(1);
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          i_d = i_up;
        end
      end
      S_WALK_HI: begin
        s1_d = s1_q + ft_rd;
        if (i_dn == '0) begin
          i_d     = IDX_W'(arg0_q[AW-1:0]);
          state_d = S_WALK_LO;
        end else begin
          i_d = i_dn;
        end
      end
      S_WALK_LO: begin
        if (i_q == '0) begin
          result_d = s1_q - s0_q;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else begin
          s0_d = s0_q + ft_rd;
          i_d  = i_dn;
        end
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = done_d & irqen_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLR;  op_q    <= OP_APPEND; i_q      <= '0; count_q <= '0;
      arg0_q  <= '0;     arg1_q  <= '0;        result_q <= '0; delta_q <= '0;
      s1_q    <= '0;     s0_q    <= '0;        done_q   <= 1'b0; err_q <= 1'b0;
      ovr_q   <= 1'b0;   irqen_q <= 1'b0;      ready_q  <= 1'b0; irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d; op_q    <= op_d;     i_q      <= i_d;      count_q <= count_d;
      arg0_q  <= arg0_d;  arg1_q  <= arg1_d;   result_q <= result_d; delta_q <= delta_d;
      s1_q    <= s1_d;    s0_q    <= s0_d;     done_q   <= done_d;   err_q   <= err_d;
      ovr_q   <= ovr_d;   irqen_q <= irqen_d;  ready_q  <= ready_d;  irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_ready = ready_q;
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_fenwick_mmio_engine.sv
// Scoreboard bench for fenwick_mmio_engine at DEPTH=8: the driver queues an expected
// read value per bus access, a monitor pops and compares on every bus_ready.
module tb_fenwick_mmio_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fenwick_mmio_if #(.DATA_W(32)) bus ();

  fenwick_mmio_engine #(.DATA_W(32), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bit          chk_q [$];
  logic [31:0] exp_q [$];
  string       nm_q  [$];
  int          checks = 0;
  int          failures = 0;

  always @(negedge clk) begin
    if (bus.bus_ready === 1'b1) begin
      if (chk_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready got ready with empty scoreboard");
      end else begin
        automatic bit          c = chk_q.pop_front();
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = nm_q.pop_front();
        if (c) begin
          checks++;
          if (bus.bus_rdata !== e) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", n, bus.bus_rdata, e);
          end
        end
      end
    end
  end

  task automatic direct(input string n, input logic [31:0] got, input logic [31:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", n, got, e);
    end
  endtask

  task automatic acc(input bit wen, input logic [2:0] a, input logic [31:0] wd,
                     input bit c, input logic [31:0] e, input string n);
    bus.bus_sel = 1'b1; bus.bus_wen = wen; bus.bus_addr = a; bus.bus_wdata = wd;
    chk_q.push_back(c & ~wen); exp_q.push_back(e); nm_q.push_back(n);
    @(negedge clk);
    bus.bus_sel = 1'b0; bus.bus_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    acc(1'b0, a, 32'h0, 1'b1, e, n);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    acc(1'b1, a, wd, 1'b0, 32'h0, "wr");
  endtask

  task automatic wait_done(input string n);
    logic [31:0] st;
    st = 32'h1;
    for (int k = 0; k < 200 && st[0]; k++) begin
      acc(1'b0, 3'd1, 32'h0, 1'b0, 32'h0, "poll");
      st = bus.bus_rdata;
    end
    if (st[0]) begin
      checks++; failures++;
      $display("FAIL %s_timeout busy still 1 after poll budget", n);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a0, input logic [31:0] a1, input string n);
    wr(3'd2, a0);
    wr(3'd3, a1);
    wr(3'd0, 32'h10 | {30'h0, op});
    wait_done(n);
  endtask

  task automatic query(input logic [31:0] ql, input logic [31:0] qr, input logic [31:0] e,
                       input logic [31:0] est, input string n);
    run(2'b01, ql, qr, n);
    rd(3'd4, e, n);
    rd(3'd1, est, {n, "_st"});
    wr(3'd1, 32'h16);
  endtask

  task automatic app(input logic [31:0] v, input logic [31:0] est, input string n);
    run(2'b00, 32'h0, v, n);
    rd(3'd1, est, {n, "_st"});
    wr(3'd1, 32'h16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bus_sel = 1'b0; bus.bus_wen = 1'b0; bus.bus_addr = 3'd0; bus.bus_wdata = 32'h0;
    repeat (3) @(negedge clk);
    direct("rst_rdata", bus.bus_rdata, 32'h0);
    direct("rst_ready", {31'h0, bus.bus_ready}, 32'h0);
    direct("rst_irq",   {31'h0, bus.irq}, 32'h0);
    rst_n = 1'b1;

    rd(3'd1, 32'h1, "clr_busy");
    repeat (4) @(negedge clk);
    rd(3'd1, 32'h1, "clr_busy_mid");
    wait_done("clr0");
    rd(3'd1, 32'h2, "clr_done");
    wr(3'd1, 32'h16);
    rd(3'd1, 32'h0, "w1c_status");
    rd(3'd5, 32'h0, "count_init");
    query(0, 7, 32'd0, 32'h2, "q07_empty");

    app(3, 32'h2, "app3"); app(1, 32'h2, "app1"); app(4, 32'h2, "app4");
    app(1, 32'h2, "app1b"); app(5, 32'h2, "app5");
    rd(3'd5, 32'd5, "count5");
    query(0, 4, 32'd14, 32'h2, "q04");
    query(1, 3, 32'd6,  32'h2, "q13");
    query(2, 2, 32'd4,  32'h2, "q22");

    run(2'b10, 2, 10, "set2");
    wr(3'd1, 32'h16);
    query(0, 4, 32'd20, 32'h2, "q04_set");
    run(2'b11, 0, 32'hFFFF_FFFF, "add0");
    wr(3'd1, 32'h16);
    query(0, 0, 32'd2,  32'h2, "q00_add");
    query(0, 7, 32'd19, 32'h2, "q07_add");

    query(5, 2, 32'd19, 32'h6, "q52_err");
    run(2'b10, 8, 99, "set8");
    rd(3'd1, 32'h6, "set8_err_st");
    rd(3'd4, 32'd19, "set8_result");
    wr(3'd1, 32'h16);
    query(0, 7, 32'd19, 32'h2, "q07_after_err");

    wr(3'd6, 32'h1);
    wr(3'd2, 0);
    wr(3'd3, 7);
    wr(3'd0, 32'h11);
    wr(3'd0, 32'h11);
    wait_done("ovr");
    rd(3'd1, 32'h12, "ovr_st");
    direct("irq_high", {31'h0, bus.irq}, 32'h1);
    rd(3'd4, 32'd19, "ovr_result");
    wr(3'd1, 32'h16);
    direct("irq_low", {31'h0, bus.irq}, 32'h0);
    wr(3'd6, 32'h0);

    app(7, 32'h2, "app7"); app(2, 32'h2, "app2"); app(6, 32'hA, "app6_full");
    app(9, 32'hE, "app9_err");
    rd(3'd5, 32'd8, "count8");
    query(0, 7, 32'd34, 32'hA, "q07_full");
    query(5, 7, 32'd15, 32'hA, "q57_full");

    wr(3'd0, 32'h20);
    wait_done("hwclr");
    rd(3'd1, 32'h2, "hwclr_st");
    wr(3'd1, 32'h16);
    rd(3'd5, 32'd0, "hwclr_count");
    query(0, 7, 32'd0, 32'h2, "q07_hwclr");

    app(5, 32'h2, "app5r"); app(6, 32'h2, "app6r");
    query(0, 1, 32'd11, 32'h2, "q01_pre");
    wr(3'd2, 0);
    wr(3'd3, 7);
    wr(3'd0, 32'h12);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd1, 32'h1, "rst2_busy");
    wait_done("rst2");
    wr(3'd1, 32'h16);
    rd(3'd5, 32'd0, "rst2_count");
    query(0, 7, 32'd0, 32'h2, "q07_rst2");
    query(0, 1, 32'd0, 32'h2, "q01_rst2");

    repeat (3) @(negedge clk);
    if (chk_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", chk_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
